// File: rtl/led_seq_pkg.sv
// Shared types, constants and the slot-search helper for the LED slot sequencer.
package led_seq_pkg;

  localparam int NUM_SLOTS = 4;

  localparam int R = 0;
  localparam int G = 1;
  localparam int B = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Returns {found, index} of the first set bit in nz, scanning start, start+1, ... modulo 4.
  function automatic logic [2:0] next_slot(input logic [1:0] start,
                                           input logic [NUM_SLOTS-1:0] nz);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      idx = start + 2'(i);
      if (nz[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Divides the clock down to a one-cycle tick every CLK_DIV cycles; clr restarts the count.
module led_tick_prescaler #(
  parameter int CLK_DIV = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == CW'(CLK_DIV - 1));
  assign tick   = w_last;

  always_ff @(posedge clk) begin
    if (rst || clr || w_last) r_count <= '0;
    else                      r_count <= r_count + 1'b1;
  end

endmodule

// File: rtl/led_slot_sequencer.sv
// Four-slot LED colour sequencer: steps through nonzero-duration slots and PWMs the latched colour.
module led_slot_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_DIV = 12000,
  parameter int DUR_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [7:0]       brightness,
  input  logic [2:0]       color0,
  input  logic [2:0]       color1,
  input  logic [2:0]       color2,
  input  logic [2:0]       color3,
  input  logic [DUR_W-1:0] duration0,
  input  logic [DUR_W-1:0] duration1,
  input  logic [DUR_W-1:0] duration2,
  input  logic [DUR_W-1:0] duration3,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             p0,
  output logic             p1,
  output logic             p2,
  output logic             p3,
  output logic             wrap_o
);

  state_t           r_state, w_state_next;
  logic [1:0]       r_k, w_k_next;
  logic [2:0]       r_color, w_color_next;
  logic [DUR_W-1:0] r_rem, w_rem_next;
  logic [3:0]       r_p, w_p_next;
  logic             r_wrap, w_wrap_next;
  logic [7:0]       r_pc;

  logic             w_tick;
  logic             w_clr;
  logic             w_enter;
  logic [1:0]       w_sel;
  logic [3:0]       w_nz;
  logic [2:0]       w_first;
  logic [2:0]       w_next;
  logic [2:0]       w_colors [NUM_SLOTS];
  logic [DUR_W-1:0] w_durs   [NUM_SLOTS];
  logic             w_pwm_on;

  assign w_colors[0] = color0;
  assign w_colors[1] = color1;
  assign w_colors[2] = color2;
  assign w_colors[3] = color3;
  assign w_durs[0]   = duration0;
  assign w_durs[1]   = duration1;
  assign w_durs[2]   = duration2;
  assign w_durs[3]   = duration3;

  assign w_nz    = {duration3 != '0, duration2 != '0, duration1 != '0, duration0 != '0};
  assign w_first = next_slot(2'd0, w_nz);
  assign w_next  = next_slot(r_k + 2'd1, w_nz);

  // The prescaler is held clear while idle so every slot starts with a full tick period.
  assign w_clr = (r_state != RUN) || w_enter;

  led_tick_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= 2'd0;
      r_color <= 3'b000;
      r_rem   <= '0;
      r_p     <= 4'b0000;
      r_wrap  <= 1'b0;
      r_pc    <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      r_color <= w_color_next;
      r_rem   <= w_rem_next;
      r_p     <= w_p_next;
      r_wrap  <= w_wrap_next;
      r_pc    <= r_pc + 8'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_color_next = r_color;
    w_rem_next   = r_rem;
    w_p_next     = r_p;
    w_wrap_next  = 1'b0;
    w_enter      = 1'b0;
    w_sel        = r_k;

    case (r_state)
      IDLE: begin
        if (enable && w_first[2]) begin
          w_state_next = RUN;
          w_enter      = 1'b1;
          w_sel        = w_first[1:0];
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_next = IDLE;
        end else if (w_tick) begin
          if (r_rem > DUR_W'(1)) begin
            w_rem_next = r_rem - 1'b1;
          end else if (w_next[2]) begin
            w_enter     = 1'b1;
            w_sel       = w_next[1:0];
            w_wrap_next = (w_next[1:0] <= r_k);
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_enter) begin
      w_k_next     = w_sel;
      w_color_next = w_colors[w_sel];
      w_rem_next   = w_durs[w_sel];
      w_p_next     = 4'b0001 << w_sel;
    end

    if (w_state_next == IDLE) begin
      w_color_next = 3'b000;
      w_rem_next   = '0;
      w_p_next     = 4'b0000;
    end
  end

  assign w_pwm_on = (r_state == RUN) && (r_pc < brightness);

  assign led_r  = w_pwm_on & r_color[R];
  assign led_g  = w_pwm_on & r_color[G];
  assign led_b  = w_pwm_on & r_color[B];

  assign p0     = r_p[0];
  assign p1     = r_p[1];
  assign p2     = r_p[2];
  assign p3     = r_p[3];
  assign wrap_o = r_wrap;

endmodule

// File: tb/tb_led_slot_sequencer.sv
// Directed self-checking bench for led_slot_sequencer with a 4-cycle tick.
module tb_led_slot_sequencer;

  localparam int CLK_DIV = 4;
  localparam int DUR_W   = 12;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [7:0]       brightness;
  logic [2:0]       color0, color1, color2, color3;
  logic [DUR_W-1:0] duration0, duration1, duration2, duration3;
  logic             led_r, led_g, led_b;
  logic             p0, p1, p2, p3;
  logic             wrap_o;

  int               assertCount;
  int               failCount;
  logic [7:0]       tbPc;
  logic [2:0]       expColors [4];

  led_slot_sequencer #(
    .CLK_DIV(CLK_DIV),
    .DUR_W  (DUR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .brightness(brightness),
    .color0    (color0),
    .color1    (color1),
    .color2    (color2),
    .color3    (color3),
    .duration0 (duration0),
    .duration1 (duration1),
    .duration2 (duration2),
    .duration3 (duration3),
    .led_r     (led_r),
    .led_g     (led_g),
    .led_b     (led_b),
    .p0        (p0),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .wrap_o    (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the free-running PWM counter.
  always @(posedge clk) begin
    if (rst) tbPc <= 8'd0;
    else     tbPc <= tbPc + 8'd1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic en, input logic [DUR_W-1:0] d0, input logic [DUR_W-1:0] d1,
                               input logic [DUR_W-1:0] d2, input logic [DUR_W-1:0] d3);
    enable    = en;
    duration0 = d0;
    duration1 = d1;
    duration2 = d2;
    duration3 = d3;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expP, input logic expWrap,
                             input logic [2:0] expColor);
    logic [2:0] expLed;
    logic [2:0] obsLed;
    logic [3:0] obsP;
    expLed = ((expP != 4'b0000) && (tbPc < brightness)) ? expColor : 3'b000;
    obsLed = {led_b, led_g, led_r};
    obsP   = {p3, p2, p1, p0};
    assertCount++;
    assert (obsP === expP) else begin
      failCount++;
      $error("[TB] FAIL %s slot pins: observed %b expected %b", tag, obsP, expP);
    end
    assertCount++;
    assert (wrap_o === expWrap) else begin
      failCount++;
      $error("[TB] FAIL %s wrap_o: observed %b expected %b", tag, wrap_o, expWrap);
    end
    assertCount++;
    assert (obsLed === expLed) else begin
      failCount++;
      $error("[TB] FAIL %s leds bgr: observed %b expected %b", tag, obsLed, expLed);
    end
  endtask

  // Durations {2,3,1,4} at 4 cycles per tick: slots last 8, 12, 4, 16 cycles; period 40.
  function automatic int slotOf(int i);
    int j;
    j = (i - 1) % 40;
    if (j < 8)  return 0;
    if (j < 20) return 1;
    if (j < 24) return 2;
    return 3;
  endfunction

  task automatic runPattern(input string tag, input int firstObs, input int lastObs);
    int s;
    for (int i = firstObs; i <= lastObs; i++) begin
      step();
      s = slotOf(i);
      checkOutput(tag, 4'b0001 << s, (i > 1) && ((i - 1) % 40 == 0), expColors[s]);
    end
  endtask

  task automatic countDuty(input string tag, input int expected);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led_g) cnt++;
    end
    assertCount++;
    assert (cnt === expected) else begin
      failCount++;
      $error("[TB] FAIL %s led_g high cycles: observed %0d expected %0d", tag, cnt, expected);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst         = 1'b1;
    brightness  = 8'h80;
    color0      = 3'd1;
    color1      = 3'd2;
    color2      = 3'd4;
    color3      = 3'd7;
    expColors[0] = 3'd1;
    expColors[1] = 3'd2;
    expColors[2] = 3'd4;
    expColors[3] = 3'd7;
    applyStimulus(1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
    repeat (3) step();
    checkOutput("reset", 4'b0000, 1'b0, 3'b000);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      step();
      checkOutput("idle_disabled", 4'b0000, 1'b0, 3'b000);
    end
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("idle_no_slots", 4'b0000, 1'b0, 3'b000);
    end

    $display("[TB] four-slot sequence with mid-slot colour write");
    applyStimulus(1'b1, 12'd2, 12'd3, 12'd1, 12'd4);
    runPattern("seq", 1, 12);
    color1 = 3'd5;
    runPattern("seq", 13, 40);
    expColors[1] = 3'd5;
    runPattern("seq_wrap", 41, 62);

    $display("[TB] disable mid-slot-2 and restart");
    enable = 1'b0;
    step();
    checkOutput("disabled", 4'b0000, 1'b0, 3'b000);
    enable = 1'b1;
    runPattern("restart", 1, 30);
    applyStimulus(1'b1, 12'd0, 12'd0, 12'd0, 12'd0);
    runPattern("drain", 31, 40);
    step();
    checkOutput("expire_idle", 4'b0000, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("stay_idle", 4'b0000, 1'b0, 3'b000);
    end

    $display("[TB] single nonzero slot");
    color1 = 3'd2;
    applyStimulus(1'b1, 12'd0, 12'd5, 12'd0, 12'd0);
    for (int i = 1; i <= 60; i++) begin
      step();
      checkOutput("solo", 4'b0010, (i > 1) && ((i - 1) % 20 == 0), 3'd2);
    end
    countDuty("duty_half", 128);
    brightness = 8'd255;
    countDuty("duty_255", 255);
    brightness = 8'd0;
    countDuty("duty_zero", 0);
    brightness = 8'h80;

    $display("[TB] reset during run");
    rst = 1'b1;
    step();
    checkOutput("reset_mid_run", 4'b0000, 1'b0, 3'b000);
    rst = 1'b0;
    step();
    checkOutput("after_reset", 4'b0010, 1'b0, 3'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
